phv_mcast_dispatch: RTL

- Final-stage PHV fan-out. Takes one PHV per handshake from the action engine and replicates it into per-queue output FIFOs.
- The destination set comes from the one-hot/multi-hot queue mask embedded in the PHV.
- Successor to the fixed 4-queue registered fan-out: queue count, mask position and FIFO depth are parametrised.
- Adds per-queue buffering, a proper valid/ready handshake per queue, a selectable stall-or-drop policy and drop counters.

---
 rtl/phv_mcast_dispatch.sv | 112 +++++++++++
 1 files changed

// File: rtl/phv_mcast_dispatch.sv
// Final-stage PHV fan-out: replicates each accepted PHV into the per-queue
// first-word-fall-through FIFOs selected by the queue mask carried in the PHV.
module phv_mcast_dispatch #(
  parameter int PHV_LEN      = 1124,
  parameter int C_NUM_QUEUES = 4,
  parameter int QMASK_OFF    = 141,
  parameter int FIFO_DEPTH   = 4,
  parameter int DROP_MODE    = 0,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                            axis_clk,
  input  logic                            areset,
  input  logic [PHV_LEN-1:0]              phv_in,
  input  logic                            phv_in_valid,
  output logic                            phv_in_ready,
  output logic [C_NUM_QUEUES*PHV_LEN-1:0] phv_out,
  output logic [C_NUM_QUEUES-1:0]         phv_out_valid,
  input  logic [C_NUM_QUEUES-1:0]         phv_out_ready,
  output logic [CNT_WIDTH-1:0]            drop_full_cnt,
  output logic [CNT_WIDTH-1:0]            drop_nomask_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [C_NUM_QUEUES-1:0] mask;
  logic [C_NUM_QUEUES-1:0] full;
  logic [C_NUM_QUEUES-1:0] push;
  logic [C_NUM_QUEUES-1:0] pop;
  logic                    accept;
  logic [4:0]              drop_pc;
  logic [CNT_WIDTH:0]      drop_full_sum;

  logic [AW-1:0]      wptr  [C_NUM_QUEUES];
  logic [AW-1:0]      rptr  [C_NUM_QUEUES];
  logic [CW-1:0]      count [C_NUM_QUEUES];
  logic [PHV_LEN-1:0] mem   [C_NUM_QUEUES][FIFO_DEPTH];

  assign mask = phv_in[QMASK_OFF +: C_NUM_QUEUES];

  // Full is taken from the registered count, so a queue popped this cycle still counts as full.
  always_comb begin
    full          = '0;
    phv_out_valid = '0;
    pop           = '0;
    drop_pc       = '0;
    for (int unsigned q = 0; q < C_NUM_QUEUES; q++) begin
      full[q]          = (count[q] == CW'(FIFO_DEPTH));
      phv_out_valid[q] = (count[q] != '0);
      pop[q]           = phv_out_valid[q] & phv_out_ready[q];
      drop_pc          = drop_pc + 5'(mask[q] & full[q]);
    end
  end

  always_comb begin
    if (DROP_MODE == 0) phv_in_ready = ~areset & ~|(mask & full);
    else                phv_in_ready = ~areset;
  end

  assign accept        = phv_in_valid & phv_in_ready;
  assign push          = accept ? (mask & ~full) : '0;
  assign drop_full_sum = {1'b0, drop_full_cnt} + (CNT_WIDTH + 1)'(drop_pc);

  // Storage is not reset; gating by valid keeps stale entries off phv_out.
  always_comb begin
    phv_out = '0;
    for (int unsigned q = 0; q < C_NUM_QUEUES; q++) begin
      if (phv_out_valid[q]) phv_out[q*PHV_LEN +: PHV_LEN] = mem[q][rptr[q]];
    end
  end

  always_ff @(posedge axis_clk) begin
    for (int unsigned q = 0; q < C_NUM_QUEUES; q++) begin
      if (push[q]) mem[q][wptr[q]] <= phv_in;
    end
  end

  always_ff @(posedge axis_clk or posedge areset) begin
    if (areset) begin
      for (int unsigned q = 0; q < C_NUM_QUEUES; q++) begin
        wptr[q]  <= '0;
        rptr[q]  <= '0;
        count[q] <= '0;
      end
    end else begin
      for (int unsigned q = 0; q < C_NUM_QUEUES; q++) begin
        if (push[q]) wptr[q] <= wptr[q] + 1'b1;
        if (pop[q])  rptr[q] <= rptr[q] + 1'b1;
        case ({push[q], pop[q]})
          2'b10:   count[q] <= count[q] + 1'b1;
          2'b01:   count[q] <= count[q] - 1'b1;
          default: count[q] <= count[q];
        endcase
      end
    end
  end

  always_ff @(posedge axis_clk or posedge areset) begin
    if (areset) begin
      drop_full_cnt   <= '0;
      drop_nomask_cnt <= '0;
    end else if (accept) begin
      if (DROP_MODE != 0) begin
        drop_full_cnt <= drop_full_sum[CNT_WIDTH] ? '1 : drop_full_sum[CNT_WIDTH-1:0];
      end
      if ((mask == '0) && (drop_nomask_cnt != '1)) begin
        drop_nomask_cnt <= drop_nomask_cnt + 1'b1;
      end
    end
  end

endmodule
